// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, FSM states and flag bit positions for the
//            sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_SUMA  = 4'd0,
    OP_RESTA = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIV   = 4'd3,
    OP_MOD   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ROTL  = 4'd10,
    OP_ROTR  = 4'd11
  } opcode_t;

  typedef enum logic [0:0] {
    LIBRE   = 1'b0,
    CALCULO = 1'b1
  } estado_t;

  // Bit positions inside the packed NZCV flag vector
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Opcodes that take the multi-cycle path
  function automatic logic es_iterativa(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_iterativo.sv
// ============================================================================
// Module   : divisor_iterativo
// Purpose  : Unsigned restoring divider, one quotient bit per cycle.
//            'start' loads the operands; 'done' is high during the last
//            iteration, while cociente/resto already show the final values.
//            A zero divisor naturally yields all-ones quotient and
//            remainder equal to the dividend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_iterativo
  import alu_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ANCHO-1:0] dividendo,
  input  logic [ANCHO-1:0] divisor,
  output logic             done,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] resto
);

  localparam int ANCHO_CNT = $clog2(ANCHO + 1);
  localparam logic [ANCHO_CNT-1:0] ULTIMO = ANCHO_CNT'(ANCHO - 1);

  logic                 activo;
  logic [ANCHO_CNT-1:0] cnt;
  logic [ANCHO-1:0]     rem;
  logic [ANCHO-1:0]     q;
  logic [ANCHO-1:0]     d;
  logic [ANCHO:0]       desplazado;
  logic [ANCHO:0]       diferencia;

  // One restoring step: shift next dividend bit in, subtract if it fits
  always_comb begin
    desplazado = {rem, q[ANCHO-1]};
    diferencia = desplazado - {1'b0, d};
    if (desplazado >= {1'b0, d}) begin
      resto    = diferencia[ANCHO-1:0];
      cociente = {q[ANCHO-2:0], 1'b1};
    end else begin
      resto    = desplazado[ANCHO-1:0];
      cociente = {q[ANCHO-2:0], 1'b0};
    end
  end

  assign done = activo && (cnt == ULTIMO);

  // Operand load and per-cycle iteration state
  always_ff @(posedge clk) begin
    if (rst) begin
      activo <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
      d      <= '0;
    end else if (start) begin
      activo <= 1'b1;
      cnt    <= '0;
      rem    <= '0;
      q      <= dividendo;
      d      <= divisor;
    end else if (activo) begin
      rem <= resto;
      q   <= cociente;
      cnt <= cnt + 1'b1;
      if (done) activo <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_secuencial.sv
// ============================================================================
// Module   : alu_secuencial
// Purpose  : Multi-cycle ALU with start/done handshake and registered NZCV
//            flags. Single-cycle ops complete at 1 per cycle; mult/div/mod
//            iterate for ANCHO cycles.
//            Optional macro ALU_ROTACION_EN enables rotate left/right on
//            opcodes 10/11 (otherwise they behave as illegal opcodes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_secuencial
  import alu_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] operandoA,
  input  logic [ANCHO-1:0] operandoB,
  input  logic [3:0]       seleccion,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] resultado,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int ANCHO_CNT = $clog2(ANCHO + 1);
  localparam logic [ANCHO_CNT-1:0] ULTIMO  = ANCHO_CNT'(ANCHO - 1);
  localparam logic [ANCHO-1:0]     ANCHO_V = ANCHO'(ANCHO);

  estado_t                estado, estado_sig;
  logic [ANCHO_CNT-1:0]   cnt;
  logic [3:0]             op_reg;
  logic [ANCHO-1:0]       a_reg;
  logic                   b_cero;
  logic [2*ANCHO-1:0]     prod, prod_sig;
  logic [ANCHO:0]         mult_suma;
  logic [3:0]             flags, flags_sc, flags_fin;
  logic [ANCHO-1:0]       res_sc, res_fin;
  logic                   c_sc, v_sc, c_fin, v_fin;
  logic                   escribir_sc, iniciar_iter, fin, ultimo;
  logic                   div_done;
  logic [ANCHO-1:0]       cociente, resto;
  logic [ANCHO:0]         ext_suma, ext_resta, ext_shl, ext_shr;
`ifdef ALU_ROTACION_EN
  logic [ANCHO-1:0]       amt, rot_l, rot_r;
`endif

  divisor_iterativo #(.ANCHO(ANCHO)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (iniciar_iter && (seleccion == OP_DIV || seleccion == OP_MOD)),
    .dividendo (operandoA),
    .divisor   (operandoB),
    .done      (div_done),
    .cociente  (cociente),
    .resto     (resto)
  );

  // Single-cycle result and carry/overflow from the live operands
  always_comb begin
    res_sc    = '0;
    c_sc      = 1'b0;
    v_sc      = 1'b0;
    ext_suma  = {1'b0, operandoA} + {1'b0, operandoB};
    ext_resta = {1'b0, operandoA} - {1'b0, operandoB};
    ext_shl   = {1'b0, operandoA} << operandoB;
    ext_shr   = {operandoA, 1'b0} >> operandoB;
`ifdef ALU_ROTACION_EN
    amt   = operandoB % ANCHO_V;
    rot_l = (operandoA << amt) | (operandoA >> (ANCHO_V - amt));
    rot_r = (operandoA >> amt) | (operandoA << (ANCHO_V - amt));
`endif
    case (seleccion)
      OP_SUMA: begin
        res_sc = ext_suma[ANCHO-1:0];
        c_sc   = ext_suma[ANCHO];
        v_sc   = (operandoA[ANCHO-1] == operandoB[ANCHO-1]) &&
                 (ext_suma[ANCHO-1] != operandoA[ANCHO-1]);
      end
      OP_RESTA: begin
        res_sc = ext_resta[ANCHO-1:0];
        c_sc   = ext_resta[ANCHO];
        v_sc   = (operandoA[ANCHO-1] != operandoB[ANCHO-1]) &&
                 (ext_resta[ANCHO-1] != operandoA[ANCHO-1]);
      end
      OP_AND: res_sc = operandoA & operandoB;
      OP_OR:  res_sc = operandoA | operandoB;
      OP_XOR: res_sc = operandoA ^ operandoB;
      OP_SHL: begin
        if (operandoB == '0) begin
          res_sc = operandoA;
        end else if (operandoB < ANCHO_V) begin
          res_sc = ext_shl[ANCHO-1:0];
          c_sc   = ext_shl[ANCHO];
        end
      end
      OP_SHR: begin
        if (operandoB == '0) begin
          res_sc = operandoA;
        end else if (operandoB < ANCHO_V) begin
          res_sc = ext_shr[ANCHO:1];
          c_sc   = ext_shr[0];
        end
      end
`ifdef ALU_ROTACION_EN
      // The bit that wrapped last lands at the LSB (rotl) or MSB (rotr)
      OP_ROTL: begin
        res_sc = rot_l;
        c_sc   = (amt != '0) && rot_l[0];
      end
      OP_ROTR: begin
        res_sc = rot_r;
        c_sc   = (amt != '0) && rot_r[ANCHO-1];
      end
`endif
      default: ;
    endcase
    flags_sc         = '0;
    flags_sc[FLAG_N] = res_sc[ANCHO-1];
    flags_sc[FLAG_Z] = (res_sc == '0);
    flags_sc[FLAG_C] = c_sc;
    flags_sc[FLAG_V] = v_sc;
  end

  // Shift-add multiply step: accumulate A into the high half, shift right
  always_comb begin
    mult_suma = {1'b0, prod[2*ANCHO-1:ANCHO]} +
                {1'b0, (prod[0] ? a_reg : {ANCHO{1'b0}})};
    prod_sig  = {mult_suma, prod[ANCHO-1:1]};
  end

  // Result and flags written by the final iteration
  always_comb begin
    res_fin = '0;
    c_fin   = 1'b0;
    v_fin   = 1'b0;
    case (op_reg)
      OP_MULT: begin
        res_fin = prod_sig[ANCHO-1:0];
        c_fin   = |prod_sig[2*ANCHO-1:ANCHO];
        v_fin   = |prod_sig[2*ANCHO-1:ANCHO];
      end
      OP_DIV: begin
        res_fin = cociente;
        v_fin   = b_cero;
      end
      OP_MOD: begin
        res_fin = resto;
        v_fin   = b_cero;
      end
      default: ;
    endcase
    flags_fin         = '0;
    flags_fin[FLAG_N] = res_fin[ANCHO-1];
    flags_fin[FLAG_Z] = (res_fin == '0);
    flags_fin[FLAG_C] = c_fin;
    flags_fin[FLAG_V] = v_fin;
  end

  assign ultimo = (op_reg == OP_MULT) ? (cnt == ULTIMO) : div_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) estado <= LIBRE;
    else     estado <= estado_sig;
  end

  // Next-state logic, accept decode and busy output
  always_comb begin
    estado_sig   = estado;
    ocupado      = 1'b0;
    escribir_sc  = 1'b0;
    iniciar_iter = 1'b0;
    fin          = 1'b0;
    case (estado)
      LIBRE: begin
        if (inicio) begin
          if (es_iterativa(seleccion)) begin
            estado_sig   = CALCULO;
            iniciar_iter = 1'b1;
          end else begin
            escribir_sc = 1'b1;
          end
        end
      end
      CALCULO: begin
        ocupado = 1'b1;
        if (ultimo) begin
          estado_sig = LIBRE;
          fin        = 1'b1;
        end
      end
      default: estado_sig = LIBRE;
    endcase
  end

  // Operand capture, iteration counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_cero    <= 1'b0;
      prod      <= '0;
      resultado <= '0;
      flags     <= '0;
      listo     <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (iniciar_iter) begin
        op_reg <= seleccion;
        a_reg  <= operandoA;
        b_cero <= (operandoB == '0);
        prod   <= {{ANCHO{1'b0}}, operandoB};
        cnt    <= '0;
      end else if (estado == CALCULO) begin
        prod <= prod_sig;
        cnt  <= cnt + 1'b1;
      end
      if (escribir_sc) begin
        resultado <= res_sc;
        flags     <= flags_sc;
        listo     <= 1'b1;
      end else if (fin) begin
        resultado <= res_fin;
        flags     <= flags_fin;
        listo     <= 1'b1;
      end
    end
  end

  assign N = flags[FLAG_N];
  assign Z = flags[FLAG_Z];
  assign C = flags[FLAG_C];
  assign V = flags[FLAG_V];

endmodule

`default_nettype wire

// File: tb/tb_alu_secuencial.sv
// ============================================================================
// Module   : tb_alu_secuencial
// Purpose  : Directed self-checking bench for alu_secuencial (ANCHO=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_secuencial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio = 1'b0;
  logic [7:0] operandoA = '0;
  logic [7:0] operandoB = '0;
  logic [3:0] seleccion = '0;
  logic       ocupado, listo, N, Z, C, V;
  logic [7:0] resultado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.ANCHO(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .operandoA (operandoA),
    .operandoB (operandoB),
    .seleccion (seleccion),
    .ocupado   (ocupado),
    .listo     (listo),
    .resultado (resultado),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V)
  );

  // Request accepted at end of cycle 0; returns at the negedge of cycle 1
  task automatic pulso(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    seleccion = op; operandoA = a; operandoB = b; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL reset_res got %h exp 00", resultado); end
    checks++; if ({N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {N, Z, C, V}); end
    checks++; if ({listo, ocupado} !== 2'b00) begin errors++; $display("FAIL reset_hs got %b exp 00", {listo, ocupado}); end
    rst = 1'b0;
  endtask

  task automatic test_suma();
    pulso(4'd0, 8'hFF, 8'h01);
    checks++; if (listo !== 1'b1) begin errors++; $display("FAIL suma_listo got %b exp 1", listo); end
    checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL suma_res got %h exp 00", resultado); end
    checks++; if ({N, Z, C, V} !== 4'b0110) begin errors++; $display("FAIL suma_flags got %b exp 0110", {N, Z, C, V}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    seleccion = 4'd0; operandoA = 8'h7F; operandoB = 8'h01; inicio = 1'b1;
    @(negedge clk);
    checks++; if (listo !== 1'b1 || resultado !== 8'h80) begin errors++; $display("FAIL b2b_suma got listo=%b res=%h exp 1 80", listo, resultado); end
    checks++; if ({N, Z, C, V} !== 4'b1001) begin errors++; $display("FAIL b2b_suma_flags got %b exp 1001", {N, Z, C, V}); end
    seleccion = 4'd1; operandoA = 8'h03; operandoB = 8'h05;
    @(negedge clk);
    inicio = 1'b0;
    checks++; if (listo !== 1'b1 || resultado !== 8'hFE) begin errors++; $display("FAIL b2b_resta got listo=%b res=%h exp 1 FE", listo, resultado); end
    checks++; if ({N, Z, C, V} !== 4'b1010) begin errors++; $display("FAIL b2b_resta_flags got %b exp 1010", {N, Z, C, V}); end
    @(negedge clk);
    checks++; if (listo !== 1'b0) begin errors++; $display("FAIL b2b_listo_drop got %b exp 0", listo); end
  endtask

  task automatic test_mult();
    pulso(4'd2, 8'h10, 8'h20);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (ocupado !== 1'b1 || listo !== 1'b0) begin errors++; $display("FAIL mult_busy_c%0d got ocupado=%b listo=%b exp 1 0", c, ocupado, listo); end
      if (c == 4) begin
        seleccion = 4'd0; operandoA = 8'h01; operandoB = 8'h01; inicio = 1'b1;
      end else begin
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (listo !== 1'b1 || ocupado !== 1'b0) begin errors++; $display("FAIL mult_done got listo=%b ocupado=%b exp 1 0", listo, ocupado); end
    checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL mult_res got %h exp 00", resultado); end
    checks++; if ({N, Z, C, V} !== 4'b0111) begin errors++; $display("FAIL mult_flags got %b exp 0111", {N, Z, C, V}); end
    @(negedge clk);
    checks++; if (listo !== 1'b0 || resultado !== 8'h00) begin errors++; $display("FAIL mult_no_extra got listo=%b res=%h exp 0 00", listo, resultado); end
    pulso(4'd2, 8'h0D, 8'h0B);
    repeat (8) @(negedge clk);
    checks++; if (listo !== 1'b1 || resultado !== 8'h8F) begin errors++; $display("FAIL mult2_res got listo=%b res=%h exp 1 8F", listo, resultado); end
    checks++; if ({N, Z, C, V} !== 4'b1000) begin errors++; $display("FAIL mult2_flags got %b exp 1000", {N, Z, C, V}); end
  endtask

  task automatic test_div();
    pulso(4'd3, 8'd200, 8'd7);
    repeat (7) @(negedge clk);
    checks++; if (listo !== 1'b0 || ocupado !== 1'b1) begin errors++; $display("FAIL div_c8 got listo=%b ocupado=%b exp 0 1", listo, ocupado); end
    @(negedge clk);
    checks++; if (listo !== 1'b1 || resultado !== 8'd28) begin errors++; $display("FAIL div_res got listo=%b res=%0d exp 1 28", listo, resultado); end
    checks++; if ({N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL div_flags got %b exp 0000", {N, Z, C, V}); end
    pulso(4'd4, 8'd200, 8'd7);
    repeat (8) @(negedge clk);
    checks++; if (listo !== 1'b1 || resultado !== 8'd4) begin errors++; $display("FAIL mod_res got listo=%b res=%0d exp 1 4", listo, resultado); end
    pulso(4'd3, 8'd5, 8'd0);
    repeat (8) @(negedge clk);
    checks++; if (listo !== 1'b1 || resultado !== 8'hFF) begin errors++; $display("FAIL div0_res got listo=%b res=%h exp 1 FF", listo, resultado); end
    checks++; if ({N, Z, C, V} !== 4'b1001) begin errors++; $display("FAIL div0_flags got %b exp 1001", {N, Z, C, V}); end
    pulso(4'd4, 8'd5, 8'd0);
    repeat (8) @(negedge clk);
    checks++; if (resultado !== 8'd5 || {N, Z, C, V} !== 4'b0001) begin errors++; $display("FAIL mod0 got res=%h flags=%b exp 05 0001", resultado, {N, Z, C, V}); end
  endtask

  task automatic test_logic_shift();
    pulso(4'd5, 8'h0F, 8'hF0);
    checks++; if (resultado !== 8'h00 || Z !== 1'b1) begin errors++; $display("FAIL and got res=%h Z=%b exp 00 1", resultado, Z); end
    pulso(4'd7, 8'hF0, 8'h3C);
    checks++; if (resultado !== 8'hCC || {N, Z, C, V} !== 4'b1000) begin errors++; $display("FAIL xor got res=%h flags=%b exp CC 1000", resultado, {N, Z, C, V}); end
    pulso(4'd6, 8'h50, 8'h05);
    checks++; if (resultado !== 8'h55) begin errors++; $display("FAIL or got %h exp 55", resultado); end
    pulso(4'd9, 8'h81, 8'd1);
    checks++; if (resultado !== 8'h40 || C !== 1'b1) begin errors++; $display("FAIL shr1 got res=%h C=%b exp 40 1", resultado, C); end
    pulso(4'd8, 8'h81, 8'd9);
    checks++; if (resultado !== 8'h00 || Z !== 1'b1 || C !== 1'b0) begin errors++; $display("FAIL shl9 got res=%h Z=%b C=%b exp 00 1 0", resultado, Z, C); end
    pulso(4'd8, 8'h81, 8'd1);
    checks++; if (resultado !== 8'h02 || C !== 1'b1) begin errors++; $display("FAIL shl1 got res=%h C=%b exp 02 1", resultado, C); end
    pulso(4'd8, 8'hA5, 8'd0);
    checks++; if (resultado !== 8'hA5 || C !== 1'b0) begin errors++; $display("FAIL shl0 got res=%h C=%b exp A5 0", resultado, C); end
    pulso(4'd9, 8'h81, 8'd8);
    checks++; if (resultado !== 8'h00 || C !== 1'b0) begin errors++; $display("FAIL shr8 got res=%h C=%b exp 00 0", resultado, C); end
    pulso(4'd9, 8'h80, 8'd7);
    checks++; if (resultado !== 8'h01 || C !== 1'b0) begin errors++; $display("FAIL shr7 got res=%h C=%b exp 01 0", resultado, C); end
  endtask

  task automatic test_reset_mid();
    int listos;
    pulso(4'd0, 8'd2, 8'd3);
    checks++; if (resultado !== 8'd5) begin errors++; $display("FAIL pre_rst got %h exp 05", resultado); end
    pulso(4'd3, 8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (resultado !== 8'h00 || {N, Z, C, V} !== 4'b0000 || {listo, ocupado} !== 2'b00) begin
      errors++; $display("FAIL rst_mid got res=%h flags=%b hs=%b exp 00 0000 00", resultado, {N, Z, C, V}, {listo, ocupado});
    end
    listos = 0;
    for (int c = 0; c < 10; c++) begin
      if (listo === 1'b1) listos++;
      @(negedge clk);
    end
    checks++; if (listos !== 0) begin errors++; $display("FAIL rst_no_listo got %0d pulses exp 0", listos); end
    pulso(4'd0, 8'd4, 8'd5);
    checks++; if (listo !== 1'b1 || resultado !== 8'd9) begin errors++; $display("FAIL post_rst got listo=%b res=%h exp 1 09", listo, resultado); end
  endtask

  task automatic test_opcode_ext();
`ifdef ALU_ROTACION_EN
    pulso(4'd10, 8'h81, 8'd1);
    checks++; if (resultado !== 8'h03 || C !== 1'b1) begin errors++; $display("FAIL rotl1 got res=%h C=%b exp 03 1", resultado, C); end
    pulso(4'd11, 8'h81, 8'd9);
    checks++; if (resultado !== 8'hC0 || {N, Z, C, V} !== 4'b1010) begin errors++; $display("FAIL rotr9 got res=%h flags=%b exp C0 1010", resultado, {N, Z, C, V}); end
    pulso(4'd10, 8'h81, 8'd8);
    checks++; if (resultado !== 8'h81 || C !== 1'b0) begin errors++; $display("FAIL rotl8 got res=%h C=%b exp 81 0", resultado, C); end
`else
    pulso(4'd0, 8'd1, 8'd1);
    pulso(4'd10, 8'h81, 8'd1);
    checks++; if (listo !== 1'b1 || resultado !== 8'h00 || {N, Z, C, V} !== 4'b0100) begin
      errors++; $display("FAIL op10 got listo=%b res=%h flags=%b exp 1 00 0100", listo, resultado, {N, Z, C, V});
    end
`endif
    pulso(4'd0, 8'd1, 8'd1);
    pulso(4'd15, 8'hFF, 8'hFF);
    checks++; if (listo !== 1'b1 || resultado !== 8'h00 || {N, Z, C, V} !== 4'b0100) begin
      errors++; $display("FAIL op15 got listo=%b res=%h flags=%b exp 1 00 0100", listo, resultado, {N, Z, C, V});
    end
  endtask

  initial begin
    test_reset();
    test_suma();
    test_back_to_back();
    test_mult();
    test_div();
    test_logic_shift();
    test_reset_mid();
    test_opcode_ext();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
